// File: rtl/uart_ctrl.sv
// UART controller: TX/RX byte FIFOs feeding 8N1 serial transmit and receive engines.
// Bridge strobes are active-low; the RX FIFO head is show-ahead and reads 0 when empty.

module uart_ctrl #(
   parameter int unsigned CLK_FREQ = 50000000,
   parameter int unsigned BAUD     = 9600,
   parameter int unsigned TX_DEPTH = 4,
   parameter int unsigned RX_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_we_n,
   input  logic       uart_re_n,
   input  logic [7:0] uart_tx_data,
   output logic       uart_tx_ready,
   output logic       uart_rx_ready,
   output logic [7:0] uart_rx_data,
   output logic       rx_err,
   output logic       txd,
   input  logic       rxd
);

   localparam int unsigned DIV = CLK_FREQ / BAUD;
   localparam int unsigned CW  = $clog2(DIV);
   localparam int unsigned TAW = $clog2(TX_DEPTH);
   localparam int unsigned RAW = $clog2(RX_DEPTH);
   localparam logic [CW-1:0] CntLast = CW'(DIV - 1);
   localparam logic [CW-1:0] CntMid  = CW'(DIV / 2 - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   logic [7:0]    tx_mem_q [TX_DEPTH];
   logic [TAW:0]  tx_wptr_q, tx_rptr_q;
   logic          tx_empty, tx_full, tx_push, tx_pop, tx_cnt_last;
   logic [7:0]    tx_head;
   state_e        tx_state_q;
   logic [CW-1:0] tx_cnt_q;
   logic [2:0]    tx_idx_q;
   logic [7:0]    tx_sh_q;
   logic          txd_q;

   logic [7:0]    rx_mem_q [RX_DEPTH];
   logic [RAW:0]  rx_wptr_q, rx_rptr_q;
   logic          rx_empty, rx_full, rx_push, rx_pop, rx_cnt_last, rx_fall;
   logic          rx_s1_q, rx_s2_q, rx_prev_q;
   state_e        rx_state_q;
   logic [CW-1:0] rx_cnt_q;
   logic [2:0]    rx_idx_q;
   logic [7:0]    rx_sh_q;
   logic          rx_err_q;

   // The engine pops whenever it is about to start a frame: from idle, or at the end of a stop bit.
   always_comb begin
      tx_cnt_last = (tx_cnt_q == CntLast);
      tx_empty    = (tx_wptr_q == tx_rptr_q);
      tx_full     = (tx_wptr_q[TAW] != tx_rptr_q[TAW]) &&
                    (tx_wptr_q[TAW-1:0] == tx_rptr_q[TAW-1:0]);
      tx_pop      = !tx_empty && ((tx_state_q == StIdle) || ((tx_state_q == StStop) && tx_cnt_last));
      tx_push     = !uart_we_n && (!tx_full || tx_pop);
      tx_head     = tx_mem_q[tx_rptr_q[TAW-1:0]];
   end

   always_comb begin
      rx_cnt_last = (rx_cnt_q == CntLast);
      rx_empty    = (rx_wptr_q == rx_rptr_q);
      rx_full     = (rx_wptr_q[RAW] != rx_rptr_q[RAW]) &&
                    (rx_wptr_q[RAW-1:0] == rx_rptr_q[RAW-1:0]);
      rx_pop      = !uart_re_n && !rx_empty;
      rx_push     = (rx_state_q == StStop) && rx_cnt_last && rx_s2_q && (!rx_full || rx_pop);
      rx_fall     = rx_prev_q && !rx_s2_q;
   end

   assign uart_tx_ready = !tx_full;
   assign uart_rx_ready = !rx_empty;
   assign uart_rx_data  = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q[RAW-1:0]];
   assign rx_err        = rx_err_q;
   assign txd           = txd_q;

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem_q[tx_wptr_q[TAW-1:0]] <= uart_tx_data;
      if (rx_push) rx_mem_q[rx_wptr_q[RAW-1:0]] <= rx_sh_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_wptr_q <= '0;
         tx_rptr_q <= '0;
         rx_wptr_q <= '0;
         rx_rptr_q <= '0;
      end else begin
         if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
         if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
         if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
         if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q <= StIdle;
         tx_cnt_q   <= '0;
         tx_idx_q   <= '0;
         tx_sh_q    <= '0;
         txd_q      <= 1'b1;
      end else begin
         unique case (tx_state_q)
            StIdle: begin
               if (tx_pop) begin
                  tx_sh_q    <= tx_head;
                  txd_q      <= 1'b0;
                  tx_cnt_q   <= '0;
                  tx_state_q <= StStart;
               end
            end
            StStart: begin
               if (tx_cnt_last) begin
                  tx_cnt_q   <= '0;
                  tx_idx_q   <= '0;
                  txd_q      <= tx_sh_q[0];
                  tx_state_q <= StData;
               end else begin
                  tx_cnt_q <= tx_cnt_q + CW'(1);
               end
            end
            StData: begin
               if (tx_cnt_last) begin
                  tx_cnt_q <= '0;
                  tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
                  if (tx_idx_q == 3'd7) begin
                     txd_q      <= 1'b1;
                     tx_state_q <= StStop;
                  end else begin
                     tx_idx_q <= tx_idx_q + 3'd1;
                     txd_q    <= tx_sh_q[1];
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + CW'(1);
               end
            end
            StStop: begin
               if (tx_cnt_last) begin
                  tx_cnt_q <= '0;
                  // Back-to-back frames: reload straight into the next start bit.
                  if (tx_pop) begin
                     tx_sh_q    <= tx_head;
                     txd_q      <= 1'b0;
                     tx_state_q <= StStart;
                  end else begin
                     tx_state_q <= StIdle;
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + CW'(1);
               end
            end
            default: tx_state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_s1_q   <= rxd;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_q <= StIdle;
         rx_cnt_q   <= '0;
         rx_idx_q   <= '0;
         rx_sh_q    <= '0;
         rx_err_q   <= 1'b0;
      end else begin
         rx_err_q <= 1'b0;
         unique case (rx_state_q)
            StIdle: begin
               if (rx_fall) begin
                  rx_cnt_q   <= '0;
                  rx_state_q <= StStart;
               end
            end
            StStart: begin
               // Mid-bit recheck filters glitches shorter than half a bit.
               if (rx_cnt_q == CntMid) begin
                  rx_cnt_q   <= '0;
                  rx_idx_q   <= '0;
                  rx_state_q <= rx_s2_q ? StIdle : StData;
               end else begin
                  rx_cnt_q <= rx_cnt_q + CW'(1);
               end
            end
            StData: begin
               if (rx_cnt_last) begin
                  rx_cnt_q <= '0;
                  rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                  if (rx_idx_q == 3'd7) rx_state_q <= StStop;
                  else                  rx_idx_q   <= rx_idx_q + 3'd1;
               end else begin
                  rx_cnt_q <= rx_cnt_q + CW'(1);
               end
            end
            StStop: begin
               if (rx_cnt_last) begin
                  rx_cnt_q   <= '0;
                  rx_state_q <= StIdle;
                  rx_err_q   <= !rx_s2_q || (rx_full && !rx_pop);
               end else begin
                  rx_cnt_q <= rx_cnt_q + CW'(1);
               end
            end
            default: rx_state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl at DIV=10: TX framing and back-to-back, RX framing/overrun table,
// and asynchronous reset mid-frame.

module tb_uart_ctrl;

   logic       clk, rst_n, uart_we_n, uart_re_n, rxd;
   logic [7:0] uart_tx_data, uart_rx_data;
   logic       uart_tx_ready, uart_rx_ready, rx_err, txd;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       pop;
      logic       pre;
      logic       post;
      int         err;
      logic [7:0] head;
   } rx_vec_t;

   rx_vec_t    vec [7];
   logic [7:0] pop_exp [4];
   logic       pre, post;
   int         errs, lows;

   uart_ctrl #(
      .CLK_FREQ(1000),
      .BAUD    (100),
      .TX_DEPTH(4),
      .RX_DEPTH(4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .uart_we_n    (uart_we_n),
      .uart_re_n    (uart_re_n),
      .uart_tx_data (uart_tx_data),
      .uart_tx_ready(uart_tx_ready),
      .uart_rx_ready(uart_rx_ready),
      .uart_rx_data (uart_rx_data),
      .rx_err       (rx_err),
      .txd          (txd),
      .rxd          (rxd)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Samples a whole frame, one comparison per bit; first sample one edge from now.
   task automatic tx_frame(input logic [7:0] b);
      logic [9:0] sh;
      logic       seen;
      sh = {1'b1, b, 1'b0};
      for (int j = 0; j < 10; j++) begin
         seen = sh[0];
         for (int c = 0; c < 10; c++) begin
            step();
            if (txd !== sh[0]) seen = txd;
         end
         check($sformatf("tx %02h bit%0d", b, j), 32'(seen), 32'(sh[0]));
         sh = sh >> 1;
      end
   endtask

   task automatic tx_idle(input string name, input int n);
      int bad;
      bad = 0;
      repeat (n) begin
         step();
         if (txd !== 1'b1) bad++;
      end
      check(name, 32'(bad), 32'd0);
   endtask

   // Drives one 8N1 frame; the stop sample lands on the 98th edge after the start.
   task automatic send_rx(input logic [7:0] b, input logic stop, input logic pop,
                          output logic pre_o, output logic post_o, output int errs_o);
      logic [9:0] sh;
      int         i;
      sh     = {stop, b, 1'b0};
      errs_o = 0;
      pre_o  = 1'b0;
      post_o = 1'b0;
      for (int j = 0; j < 10; j++) begin
         for (int c = 0; c < 10; c++) begin
            i   = j * 10 + c;
            rxd = sh[0];
            step();
            if (rx_err === 1'b1) errs_o++;
            if (i == 96) begin
               pre_o = uart_rx_ready;
               if (pop) uart_re_n = 1'b0;
            end
            if (i == 97) begin
               post_o    = uart_rx_ready;
               uart_re_n = 1'b1;
            end
         end
         sh = sh >> 1;
      end
      rxd = 1'b1;
   endtask

   initial begin
      vec[0] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1, 8'h00};
      vec[1] = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 0, 8'h11};
      vec[2] = '{8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 0, 8'h11};
      vec[3] = '{8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 0, 8'h11};
      vec[4] = '{8'h44, 1'b1, 1'b0, 1'b1, 1'b1, 0, 8'h11};
      vec[5] = '{8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 1, 8'h11};
      vec[6] = '{8'h66, 1'b1, 1'b1, 1'b1, 1'b1, 0, 8'h22};
      pop_exp[0] = 8'h22;
      pop_exp[1] = 8'h33;
      pop_exp[2] = 8'h44;
      pop_exp[3] = 8'h66;

      rst_n        = 1'b0;
      uart_we_n    = 1'b1;
      uart_re_n    = 1'b1;
      uart_tx_data = 8'h00;
      rxd          = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      check("reset txd", 32'(txd), 32'd1);
      check("reset tx_ready", 32'(uart_tx_ready), 32'd1);
      check("reset rx_ready", 32'(uart_rx_ready), 32'd0);
      check("reset rx_data", 32'(uart_rx_data), 32'd0);
      check("reset rx_err", 32'(rx_err), 32'd0);

      // Single byte: txd falls on the second edge after the write cycle.
      uart_tx_data = 8'h55;
      uart_we_n    = 1'b0;
      step();
      uart_we_n = 1'b1;
      check("t1 txd high one edge after write", 32'(txd), 32'd1);
      tx_frame(8'h55);
      tx_idle("t1 idle after frame", 10);
      check("t1 tx_ready", 32'(uart_tx_ready), 32'd1);

      // Five writes: byte 1 pops immediately, so 2..5 fill the FIFO; a sixth is dropped.
      fork
         begin
            uart_tx_data = 8'h01;
            uart_we_n    = 1'b0;
            step();
            uart_tx_data = 8'h02;
            step();
            uart_tx_data = 8'h03;
            step();
            uart_tx_data = 8'h04;
            step();
            check("t2 tx_ready with 3 queued", 32'(uart_tx_ready), 32'd1);
            uart_tx_data = 8'h05;
            step();
            check("t2 tx_ready full", 32'(uart_tx_ready), 32'd0);
            uart_tx_data = 8'h06;
            step();
            uart_we_n = 1'b1;
            check("t2 tx_ready full after dropped write", 32'(uart_tx_ready), 32'd0);
         end
         begin
            @(posedge clk);
            for (int k = 1; k <= 5; k++) tx_frame(8'(k));
            tx_idle("t2 idle after 5 frames", 20);
         end
      join
      check("t2 tx_ready drained", 32'(uart_tx_ready), 32'd1);

      // Receive 0xA3, then pop it.
      send_rx(8'hA3, 1'b1, 1'b0, pre, post, errs);
      check("t3 rx_ready before stop sample", 32'(pre), 32'd0);
      check("t3 rx_ready after stop sample", 32'(post), 32'd1);
      check("t3 rx_err", 32'(errs), 32'd0);
      check("t3 rx_data", 32'(uart_rx_data), 32'hA3);
      uart_re_n = 1'b0;
      step();
      uart_re_n = 1'b1;
      check("t3 rx_ready after pop", 32'(uart_rx_ready), 32'd0);
      check("t3 rx_data after pop", 32'(uart_rx_data), 32'd0);

      // Short glitch must be rejected as a false start.
      rxd = 1'b0;
      repeat (3) step();
      rxd  = 1'b1;
      errs = 0;
      repeat (120) begin
         step();
         if (rx_err === 1'b1) errs++;
      end
      check("t4 glitch rx_err", 32'(errs), 32'd0);
      check("t4 glitch rx_ready", 32'(uart_rx_ready), 32'd0);

      // Framing error, then fill, overrun and simultaneous pop/push on a full FIFO.
      for (int k = 0; k < 7; k++) begin
         send_rx(vec[k].data, vec[k].stop, vec[k].pop, pre, post, errs);
         repeat (10) step();
         check($sformatf("rx vec%0d ready pre", k), 32'(pre), 32'(vec[k].pre));
         check($sformatf("rx vec%0d ready post", k), 32'(post), 32'(vec[k].post));
         check($sformatf("rx vec%0d err cycles", k), 32'(errs), 32'(vec[k].err));
         check($sformatf("rx vec%0d head", k), 32'(uart_rx_data), 32'(vec[k].head));
      end
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rx pop%0d data", k), 32'(uart_rx_data), 32'(pop_exp[k]));
         uart_re_n = 1'b0;
         step();
         uart_re_n = 1'b1;
      end
      check("rx drained ready", 32'(uart_rx_ready), 32'd0);
      check("rx drained data", 32'(uart_rx_data), 32'd0);

      // Reset in the middle of a TX start bit with bytes queued on both sides.
      send_rx(8'h77, 1'b1, 1'b0, pre, post, errs);
      repeat (10) step();
      check("t6 rx byte held", 32'(uart_rx_ready), 32'd1);
      uart_tx_data = 8'hC3;
      uart_we_n    = 1'b0;
      step();
      uart_tx_data = 8'h3C;
      step();
      uart_tx_data = 8'h81;
      step();
      uart_we_n = 1'b1;
      step();
      step();
      check("t6 txd low mid start bit", 32'(txd), 32'd0);
      #3 rst_n = 1'b0;
      #1;
      check("t6 async txd", 32'(txd), 32'd1);
      check("t6 async tx_ready", 32'(uart_tx_ready), 32'd1);
      check("t6 async rx_ready", 32'(uart_rx_ready), 32'd0);
      check("t6 async rx_data", 32'(uart_rx_data), 32'd0);
      #10 rst_n = 1'b1;
      lows = 0;
      repeat (150) begin
         step();
         if (txd !== 1'b1) lows++;
      end
      check("t6 no resumed frame", 32'(lows), 32'd0);
      check("t6 tx_ready after reset", 32'(uart_tx_ready), 32'd1);
      check("t6 rx_ready after reset", 32'(uart_rx_ready), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
